// File: rtl/tlc_pkg.sv
// Shared definitions for the N-approach traffic light controller.
// Provides the phase encoding, the per-approach lamp codes and a helper that
// derives the approach-index width from the approach count.
package tlc_pkg;

    localparam int unsigned PHASE_W = 2;
    localparam int unsigned LAMP_W  = 3;

    typedef logic [PHASE_W-1:0] phase_t;
    typedef logic [LAMP_W-1:0]  lamp_t;

    // Phase codes, also the FSM state encoding
    localparam logic [1:0] PH_ALL_RED = 2'd0;
    localparam logic [1:0] PH_GREEN   = 2'd1;
    localparam logic [1:0] PH_YELLOW  = 2'd2;

    // Lamp slice encoding {red, yellow, green}
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // Approach index width; at least one bit even for degenerate counts
    function automatic int unsigned dir_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/tlc_if.sv
// Sensor-side / lamp-side bundle of the traffic light controller.
//   req, emg_req, emg_dir          : sensor front-end -> controller
//   lights, active_dir, phase,
//   emg_active                     : controller -> lamp drivers / monitoring
// master = sensor front-end / observer, slave = controller.
interface tlc_if
    import tlc_pkg::*;
#(
    parameter int unsigned N_DIR = 4,
    parameter int unsigned DW    = dir_width(N_DIR)
);
    logic [N_DIR-1:0]   req;
    logic               emg_req;
    logic [DW-1:0]      emg_dir;
    logic [3*N_DIR-1:0] lights;
    logic [DW-1:0]      active_dir;
    phase_t             phase;
    logic               emg_active;

    modport master (
        output req, emg_req, emg_dir,
        input  lights, active_dir, phase, emg_active
    );

    modport slave (
        input  req, emg_req, emg_dir,
        output lights, active_dir, phase, emg_active
    );
endinterface

// File: rtl/tlc_rr_arbiter.sv
// Round-robin pick of the first pending approach strictly after ptr,
// wrapping around so that ptr itself is considered last.
//   pend  : pending request vector
//   ptr   : last served approach
//   grant : selected approach (valid when found)
//   found : any approach pending
module tlc_rr_arbiter
    import tlc_pkg::*;
#(
    parameter int unsigned N_DIR = 4,
    parameter int unsigned DW    = dir_width(N_DIR)
) (
    input  logic [N_DIR-1:0] pend,
    input  logic [DW-1:0]    ptr,
    output logic [DW-1:0]    grant,
    output logic             found
);
    // Wide enough to hold ptr + 1 + offset, at most 2*N_DIR-1
    localparam int unsigned SW = $clog2(2 * N_DIR);

    logic [2*N_DIR-1:0] dbl;
    logic [N_DIR-1:0]   rot;
    logic [SW-1:0]      start;
    logic [SW-1:0]      off;
    logic [SW-1:0]      sum;

    // Rotate pend so bit 0 is the approach after ptr, then take the lowest set bit
    always_comb begin
        dbl   = {pend, pend};
        start = SW'(ptr) + SW'(1);
        rot   = dbl[start +: N_DIR];
        found = |pend;
        off   = '0;
        for (int j = int'(N_DIR) - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = SW'(j);
            end
        end
        sum = start + off;
        if (sum >= SW'(N_DIR)) begin
            sum = sum - SW'(N_DIR);
        end
        grant = DW'(sum);
    end

endmodule

// File: rtl/traffic_light_controller_n.sv
// N-approach traffic light controller with sensor requests, min/max green,
// gap-out, round-robin service and emergency preemption.
//   clk      : clock, rising edge
//   reset_n  : synchronous active-low reset
//   bus      : tlc_if slave (req/emg_req/emg_dir in; lights/active_dir/phase/emg_active out)
// All outputs come straight from registers.
module traffic_light_controller_n
    import tlc_pkg::*;
#(
    parameter int unsigned N_DIR      = 4,
    parameter int unsigned MIN_GREEN  = 8,
    parameter int unsigned MAX_GREEN  = 32,
    parameter int unsigned YELLOW_CYC = 3,
    parameter int unsigned ALLRED_CYC = 2,
    parameter int unsigned DW         = dir_width(N_DIR)
) (
    input  logic clk,
    input  logic reset_n,
    tlc_if.slave bus
);
    localparam int unsigned TMAX = (YELLOW_CYC > ALLRED_CYC) ? YELLOW_CYC : ALLRED_CYC;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned EW   = $clog2(MAX_GREEN + 1);

    phase_t             phase_q, phase_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [EW-1:0]      elapsed_q, elapsed_d;
    logic [DW-1:0]      active_q, active_d;
    logic [N_DIR-1:0]   pend_q, pend_d;
    logic               emg_q, emg_d;
    logic [3*N_DIR-1:0] lights_q, lights_d;

    logic [N_DIR-1:0]   act_oh;
    logic [N_DIR-1:0]   clr;
    logic [DW-1:0]      emg_dir_eff;
    logic               others_pend;
    logic               emg_hold;
    logic [DW-1:0]      rr_grant;
    logic               rr_found;

    tlc_rr_arbiter #(
        .N_DIR (N_DIR),
        .DW    (DW)
    ) u_arb (
        .pend  (pend_q),
        .ptr   (active_q),
        .grant (rr_grant),
        .found (rr_found)
    );

    // Out-of-range preemption targets fall back to the main road
    assign emg_dir_eff = (32'(bus.emg_dir) >= N_DIR) ? '0 : bus.emg_dir;

    // Next-state, pending update and lamp decode
    always_comb begin
        phase_d   = phase_q;
        timer_d   = timer_q;
        elapsed_d = elapsed_q;
        active_d  = active_q;
        emg_d     = 1'b0;
        lights_d  = {N_DIR{LAMP_RED}};
        act_oh    = '0;
        act_oh[active_q] = 1'b1;

        // The active approach is served while green, so its request is absorbed
        clr         = (phase_q == PH_GREEN) ? act_oh : '0;
        pend_d      = (pend_q | bus.req) & ~clr;
        others_pend = |(pend_q & ~act_oh);
        emg_hold    = bus.emg_req && (emg_dir_eff == active_q);

        case (phase_q)
            PH_ALL_RED: begin
                if (timer_q <= TW'(1)) begin
                    phase_d   = PH_GREEN;
                    elapsed_d = EW'(1);
                    if (bus.emg_req) begin
                        active_d = emg_dir_eff;
                    end else if (rr_found) begin
                        active_d = rr_grant;
                    end else begin
                        active_d = '0;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            PH_GREEN: begin
                if (bus.emg_req && !emg_hold) begin
                    // Preemption to another approach ignores the minimum green
                    phase_d = PH_YELLOW;
                    timer_d = TW'(YELLOW_CYC);
                end else if (!bus.emg_req && (elapsed_q >= EW'(MIN_GREEN)) && others_pend &&
                             (!bus.req[active_q] || (elapsed_q == EW'(MAX_GREEN)))) begin
                    phase_d = PH_YELLOW;
                    timer_d = TW'(YELLOW_CYC);
                end else if (!bus.emg_req && (elapsed_q != EW'(MAX_GREEN))) begin
                    // Elapsed count is frozen while held green for preemption
                    elapsed_d = elapsed_q + EW'(1);
                end
            end
            PH_YELLOW: begin
                if (timer_q <= TW'(1)) begin
                    phase_d = PH_ALL_RED;
                    timer_d = TW'(ALLRED_CYC);
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                phase_d = PH_ALL_RED;
                timer_d = TW'(ALLRED_CYC);
            end
        endcase

        emg_d = (phase_d == PH_GREEN) && bus.emg_req && (emg_dir_eff == active_d);

        for (int i = 0; i < int'(N_DIR); i++) begin
            if (DW'(i) == active_d) begin
                if (phase_d == PH_GREEN) begin
                    lights_d[3*i +: 3] = LAMP_GRN;
                end else if (phase_d == PH_YELLOW) begin
                    lights_d[3*i +: 3] = LAMP_YEL;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_q   <= PH_ALL_RED;
            timer_q   <= TW'(ALLRED_CYC);
            elapsed_q <= '0;
            active_q  <= '0;
            pend_q    <= '0;
            emg_q     <= 1'b0;
            lights_q  <= {N_DIR{LAMP_RED}};
        end else begin
            phase_q   <= phase_d;
            timer_q   <= timer_d;
            elapsed_q <= elapsed_d;
            active_q  <= active_d;
            pend_q    <= pend_d;
            emg_q     <= emg_d;
            lights_q  <= lights_d;
        end
    end

    assign bus.lights     = lights_q;
    assign bus.active_dir = active_q;
    assign bus.phase      = phase_q;
    assign bus.emg_active = emg_q;

endmodule

// File: doc/traffic_light_controller_n.md
# traffic_light_controller_n

Parametrised N-approach traffic light controller: the successor to the two-road highway/country controller, generalised to `N_DIR` approaches. It adds vehicle-sensor requests, minimum and maximum green times with gap-out, round-robin service and an emergency-preemption input. It sits between the intersection sensor front-end and the lamp drivers, one instance per intersection.

## Interface
- `N_DIR`, 4: number of approaches, 2..8; approach 0 is the main road (rest approach).
- `MIN_GREEN`, 8: minimum green cycles, ≥1.
- `MAX_GREEN`, 32: maximum green cycles while other approaches wait, > `MIN_GREEN`.
- `YELLOW_CYC`, 3: yellow cycles, ≥1.
- `ALLRED_CYC`, 2: all-red clearance cycles, ≥1.
- `DW`, `$clog2(N_DIR)`: approach index width (derived).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req`  in  N_DIR  per-approach vehicle-present sensor, level.
- `emg_req`  in  1  emergency preemption request, level.
- `emg_dir`  in  DW  approach to preempt to; sampled while `emg_req`=1.
- `lights`  out  3*N_DIR  per-approach lamps, slice i = `lights[3i+2:3i]` = {red, yellow, green}.
- `active_dir`  out  DW  approach currently or last served.
- `phase`  out  2  0=ALL_RED, 1=GREEN, 2=YELLOW.
- `emg_active`  out  1  high while GREEN is held for `emg_dir` under preemption.

## Operation
- Reset (`reset_n`=0 at an edge): phase ALL_RED, `active_dir`=0, all `lights` slices 3'b100, pending cleared, timer loaded with `ALLRED_CYC`, `emg_active`=0.
- Pending register: `pend <= (pend | req) & ~clr`. `clr` is onehot(`active_dir`) while in GREEN.
- ALL_RED: all slices red. At timer expiry, select the next approach and enter GREEN:
  - if `emg_req`=1: `emg_dir`;
  - else: the first pending approach in round-robin order starting at `active_dir`+1 (mod N_DIR);
  - else: approach 0.
- GREEN: the active slice is 3'b001; all others are red. The elapsed counter counts up from 1 and saturates at `MAX_GREEN`. Leave to YELLOW when any of these holds:
  - `emg_req`=1 and `emg_dir`≠`active_dir`. This takes effect immediately and ignores `MIN_GREEN`.
  - No preemption, elapsed ≥ `MIN_GREEN`, another approach is pending, and either `req[active_dir]`=0 (gap-out) or elapsed = `MAX_GREEN` (max-out).
- GREEN is held indefinitely in two cases:
  - no other approach is pending (rest);
  - `emg_req`=1 with `emg_dir`=`active_dir`. In this case `emg_active`=1 and the elapsed counter is frozen.
- YELLOW: the active slice is 3'b010. After `YELLOW_CYC` cycles, go to ALL_RED with the timer loaded to `ALLRED_CYC`. An `emg_req` arriving during YELLOW or ALL_RED does not shorten them.
- Safety invariant: at most one slice is non-red in any cycle; no GREEN→GREEN transition without YELLOW then ALL_RED. A change of approach always passes through YELLOW and ALL_RED.
- `emg_dir` ≥ `N_DIR` is treated as approach 0.

## Timing
- All outputs are registered Moore outputs decoded from state registers. There is no combinational path from inputs to outputs.
- A state entered at edge k holds for exactly its cycle count: YELLOW `YELLOW_CYC` and ALL_RED `ALLRED_CYC` edges. GREEN lasts ≥ `MIN_GREEN` edges unless preempted.
- A request asserted at edge k is visible in `pend` at edge k+1. The earliest decision using it is at edge k+1.
- Round-robin pointer = `active_dir`. It updates only on ALL_RED→GREEN.
- Simultaneous `req` of the active approach and its own `clr`: the request is absorbed, with no re-service.
- Reset mid-operation: the next edge forces the reset state regardless of phase and timer.

## Structure
- Package `tlc_pkg`: phase codes (ALL_RED/GREEN/YELLOW), lamp constants LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001.
- Sub-module `tlc_rr_arbiter`: combinational round-robin pick of the first set bit of `pend` after `active_dir`, plus a found flag.
- Top module: phase FSM, down-timer for YELLOW/ALL_RED, elapsed counter for GREEN, pending register, lamp decode.

## Test plan
- Reset release, no requests: 2 cycles ALL_RED (all slices 3'b100), then approach 0 green indefinitely; `active_dir`=0 throughout.
- With approach 0 green for 20 cycles, pulse `req[2]` for 1 cycle and drop `req[0]`: YELLOW on slice 0 for 3 cycles, ALL_RED for 2 cycles, then slice 2 green. `pend[2]` clears on entering green.
- `req[0]` held high, `req[1]` held high: approach 0 max-outs at exactly 32 green cycles, then approach 1 is served. Approach 1 max-outs and service returns to 0 (round-robin 0→1→0 with `req[3]`=0 skipped).
- Approach 1 green for 2 cycles, assert `emg_req` with `emg_dir`=3: immediate YELLOW (`MIN_GREEN` ignored), then 3 yellow, 2 all-red, then slice 3 green with `emg_active`=1, held while `emg_req`=1. On release, normal gap/max rules resume.
- Assert `reset_n`=0 during cycle 2 of YELLOW: the next edge shows all red, phase 0, `pend`=0, `active_dir`=0.
- Every cycle of every test: assert at most one non-red slice, and that YELLOW always precedes ALL_RED.
